// File: rtl/pc_config_loader_if.sv
// pc_config_loader_if: handshake/config bus between the system side (master) and the CGRA config loader (slave)
// start/stop/cfg_din/cfg_din_v in; cfg_din_r, config_bits, enables, busy, load_done out of the loader
interface pc_config_loader_if #(
  parameter int NUM_PCS = 16,
  parameter int CFG_WIDTH = 108,
  parameter int WORD_WIDTH = 32
);
  logic start;
  logic stop;
  logic [WORD_WIDTH-1:0] cfg_din;
  logic cfg_din_v;
  logic cfg_din_r;
  logic [NUM_PCS*CFG_WIDTH-1:0] config_bits;
  logic [1:0] enables;
  logic busy;
  logic load_done;
  modport master(output start, stop, cfg_din, cfg_din_v, input cfg_din_r, config_bits, enables, busy, load_done);
  modport slave(input start, stop, cfg_din, cfg_din_v, output cfg_din_r, config_bits, enables, busy, load_done);
endinterface

// File: rtl/pc_config_loader.sv
// pc_config_loader: assembles 32-bit config words into per-PC config vectors and sequences IDLE/LOAD/ACTIVE
// clk, rst (async active-high); bus: slave side of pc_config_loader_if
module pc_config_loader #(
  parameter int NUM_PCS = 16,
  parameter int CFG_WIDTH = 108,
  parameter int WORD_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  pc_config_loader_if.slave bus
);
  localparam int WPP = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int TOTAL = NUM_PCS * WPP;
  localparam int CW = TOTAL > 1 ? $clog2(TOTAL) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_en;
  logic r_done;
  logic w_hs;
  assign bus.busy = r_state == LOAD;
  assign bus.cfg_din_r = r_state == LOAD && !bus.stop;
  assign bus.enables = {2{r_en}};
  assign bus.load_done = r_done;
  assign w_hs = bus.cfg_din_v && bus.cfg_din_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_en <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE:
          if (bus.start && !bus.stop) begin
            r_state <= LOAD;
            r_cnt <= '0;
          end
        LOAD:
          if (bus.stop) r_state <= IDLE;
          else if (w_hs) begin
            if (r_cnt == CW'(TOTAL - 1)) begin
              r_state <= ACTIVE;
              r_en <= 1'b1;
              r_done <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
        ACTIVE:
          if (bus.stop) begin
            r_state <= IDLE;
            r_en <= 1'b0;
          end else if (bus.start) begin
            r_state <= LOAD;
            r_cnt <= '0;
            r_en <= 1'b0;
          end
        default: r_state <= IDLE;
      endcase
    end
  for (genvar p = 0; p < NUM_PCS; p++) begin : g_pc
    for (genvar w = 0; w < WPP; w++) begin : g_w
      localparam int LO = w * WORD_WIDTH;
      localparam int N = CFG_WIDTH - LO < WORD_WIDTH ? CFG_WIDTH - LO : WORD_WIDTH;
      logic [N-1:0] r_word;
      always_ff @(posedge clk or posedge rst)
        if (rst) r_word <= '0;
        else if (w_hs && r_cnt == CW'(p * WPP + w)) r_word <= bus.cfg_din[N-1:0];
      assign bus.config_bits[p*CFG_WIDTH+LO +: N] = r_word;
    end
  end
endmodule

// File: tb/tb_pc_config_loader.sv
// tb_pc_config_loader: directed bench for pc_config_loader with a load_done-driven scoreboard
module tb_pc_config_loader;
  localparam int NP = 2;
  localparam int CFW = 108;
  localparam int WW = 32;
  localparam int VW = NP * CFW;
  localparam logic [VW-1:0] E1 = {12'h008, 32'h7, 32'h6, 32'h5, 12'h004, 32'h3, 32'h2, 32'h1};
  localparam logic [VW-1:0] EF = '1;
  localparam logic [VW-1:0] EA = {108'h0, 12'h000, 32'h3, 32'h2, 32'h1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  logic [VW-1:0] exp_q[$];
  pc_config_loader_if #(.NUM_PCS(NP), .CFG_WIDTH(CFW), .WORD_WIDTH(WW)) bus();
  pc_config_loader #(.NUM_PCS(NP), .CFG_WIDTH(CFW), .WORD_WIDTH(WW)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t0 = cyc - 1;
  endtask
  task automatic stream(input bit ones, input bit bubbles);
    for (int i = 0; i < 8; i++) begin
      bus.cfg_din = ones ? 32'hFFFF_FFFF : 32'(i + 1);
      bus.cfg_din_v = 1'b1;
      bus.start = bubbles && i == 3;
      tick();
      bus.start = 1'b0;
      if (bubbles && i < 7) begin
        bus.cfg_din_v = 1'b0;
        tick();
      end
    end
    bus.cfg_din_v = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int lat);
    logic [VW-1:0] e;
    int n = 0;
    while (!bus.load_done && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, bus.load_done, 1);
    chk({tag, "_lat"}, cyc - t0, lat);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    chk({tag, "_cfg"}, bus.config_bits, e);
    chk({tag, "_en"}, bus.enables, 2'b11);
    chk({tag, "_busy"}, bus.busy, 0);
    tick();
    chk({tag, "_done_clr"}, bus.load_done, 0);
    chk({tag, "_en_hold"}, bus.enables, 2'b11);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.cfg_din = '0;
    bus.cfg_din_v = 1'b0;
    tick();
    tick();
    chk("rst_en", bus.enables, 0);
    chk("rst_cfg", bus.config_bits, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.load_done, 0);
    rst = 1'b0;
    bus.cfg_din = 32'hDEAD_BEEF;
    bus.cfg_din_v = 1'b1;
    #1;
    chk("idle_rdy", bus.cfg_din_r, 0);
    tick();
    chk("idle_cfg", bus.config_bits, 0);
    bus.cfg_din_v = 1'b0;
    do_start();
    chk("load_busy", bus.busy, 1);
    chk("load_rdy", bus.cfg_din_r, 1);
    chk("load_en", bus.enables, 0);
    exp_q.push_back(E1);
    stream(1'b0, 1'b0);
    wait_done("full", 9);
    do_start();
    chk("reconf_en", bus.enables, 0);
    chk("reconf_busy", bus.busy, 1);
    exp_q.push_back(EF);
    stream(1'b1, 1'b0);
    wait_done("ones", 9);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk("prio_act_busy", bus.busy, 0);
    chk("prio_act_en", bus.enables, 0);
    chk("prio_act_rdy", bus.cfg_din_r, 0);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk("prio_idle_busy", bus.busy, 0);
    chk("prio_idle_cfg", bus.config_bits, EF);
    do_start();
    exp_q.push_back(E1);
    stream(1'b0, 1'b1);
    wait_done("bubble", 16);
    rst = 1'b1;
    #1;
    chk("arst_en", bus.enables, 0);
    chk("arst_cfg", bus.config_bits, 0);
    chk("arst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    do_start();
    for (int i = 0; i < 3; i++) begin
      bus.cfg_din = 32'(i + 1);
      bus.cfg_din_v = 1'b1;
      tick();
    end
    bus.cfg_din = 32'h4;
    bus.stop = 1'b1;
    #1;
    chk("abort_rdy", bus.cfg_din_r, 0);
    tick();
    bus.stop = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_en", bus.enables, 0);
    chk("abort_cfg", bus.config_bits, EA);
    tick();
    chk("abort_idle_cfg", bus.config_bits, EA);
    chk("abort_idle_rdy", bus.cfg_din_r, 0);
    bus.cfg_din_v = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
